// File: rtl/pre_if_pkg.sv
// rtl/pre_if_pkg.sv - shared pipeline widths, reset PC, pre-fetch state and redirect-kind types
package pre_if_pkg;

  localparam int PF_IF_BUS_W = 34;
  localparam int IF_ID_BUS_W = 65;
  localparam int ID_IF_BUS_W = 33;

  localparam logic [31:0] DEF_RESET_PC = 32'h1c000000;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_HOLD,
    PF_STALL
  } pf_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_EX,
    RD_ERTN,
    RD_BR
  } rd_kind_t;

  // Exception beats ertn beats branch when several arrive in the same cycle.
  function automatic rd_kind_t rd_pick(input logic ex, input logic ertn, input logic br);
    if (ex)        return RD_EX;
    else if (ertn) return RD_ERTN;
    else if (br)   return RD_BR;
    else           return RD_NONE;
  endfunction

endpackage

// File: rtl/pre_if_if.sv
// rtl/pre_if_if.sv - instruction SRAM-like request bus between pre-fetch and memory
interface pre_if_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;

  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok);
endinterface

// File: rtl/pre_if_redirect_latch.sv
// rtl/pre_if_redirect_latch.sv - redirect priority select plus a hold register for redirects
// that arrive while a fetch is still in flight
module pf_redirect_latch
  import pre_if_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        capture,
  input  logic        clear,
  output logic        redir,
  output logic [31:0] redir_target,
  output logic        rd_valid,
  output logic [31:0] rd_target
);

  rd_kind_t kind;
  rd_kind_t rd_kind;
  logic     take;

  assign kind  = rd_pick(wb_ex, ertn_flush, br_taken);
  assign redir = (kind != RD_NONE);

  always_comb begin
    redir_target = br_target;
    case (kind)
      RD_EX:   redir_target = ex_entry;
      RD_ERTN: redir_target = ertn_entry;
      default: redir_target = br_target;
    endcase
  end

  // A held exception/ertn target must not be clobbered by a later branch from a squashed path.
  assign take     = capture && redir &&
                    ((kind != RD_BR) || (rd_kind == RD_NONE) || (rd_kind == RD_BR));
  assign rd_valid = (rd_kind != RD_NONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_kind   <= RD_NONE;
      rd_target <= 32'd0;
    end else if (clear) begin
      rd_kind   <= RD_NONE;
    end else if (take) begin
      rd_kind   <= kind;
      rd_target <= redir_target;
    end
  end

endmodule

// File: rtl/pre_if.sv
// rtl/pre_if.sv - pre-fetch stage: picks the next fetch PC, issues it on the instruction bus
// and hands accepted PCs to IF, tagging fetches overtaken by a redirect as discard
module pre_if
  import pre_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   if_allowin,
  output logic                   pf_if_valid,
  output logic [PF_IF_BUS_W-1:0] pf_if_bus,
  input  logic [ID_IF_BUS_W-1:0] id_if_bus,
  input  logic                   wb_ex,
  input  logic [31:0]            ex_entry,
  input  logic                   ertn_flush,
  input  logic [31:0]            ertn_entry,
  pre_if_if.master               inst_sram
);

  pf_state_t   state, nxt_state;
  logic [31:0] req_pc, nxt_req_pc, next_addr;
  logic        discard, nxt_discard;
  logic        adef, nxt_adef;
  logic        load;
  logic        req_q;
  logic [31:0] addr_q;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redir, rd_valid;
  logic [31:0] redir_target, rd_target;

  assign br_taken  = id_if_bus[32];
  assign br_target = id_if_bus[31:0];

  pf_redirect_latch u_redirect_latch (
    .clk          (clk),
    .resetn       (resetn),
    .wb_ex        (wb_ex),
    .ex_entry     (ex_entry),
    .ertn_flush   (ertn_flush),
    .ertn_entry   (ertn_entry),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .capture      (redir & ~load),
    .clear        (load),
    .redir        (redir),
    .redir_target (redir_target),
    .rd_valid     (rd_valid),
    .rd_target    (rd_target)
  );

  assign next_addr = redir    ? redir_target :
                     rd_valid ? rd_target    : req_pc + 32'd4;

  always_comb begin
    nxt_state   = state;
    nxt_req_pc  = req_pc;
    nxt_discard = discard;
    nxt_adef    = adef;
    load        = 1'b0;
    case (state)
      PF_IDLE: load = 1'b1;
      PF_REQ: begin
        if (redir)             nxt_discard = 1'b1;
        if (inst_sram.addr_ok) nxt_state   = PF_HOLD;
      end
      PF_HOLD: begin
        if (if_allowin) begin
          // A clean misaligned entry parks the stage until a redirect arrives.
          if (adef && !discard) begin
            nxt_state = PF_STALL;
            if (redir) nxt_discard = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else if (redir) begin
          nxt_discard = 1'b1;
        end
      end
      PF_STALL: if (redir || rd_valid) load = 1'b1;
      default: nxt_state = PF_IDLE;
    endcase
    if (load) begin
      nxt_req_pc  = next_addr;
      nxt_discard = 1'b0;
      nxt_adef    = (next_addr[1:0] != 2'b00);
      nxt_state   = (next_addr[1:0] != 2'b00) ? PF_HOLD : PF_REQ;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= PF_IDLE;
      req_pc      <= RESET_PC - 32'd4;
      discard     <= 1'b0;
      adef        <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= 32'd0;
      pf_if_valid <= 1'b0;
      pf_if_bus   <= '0;
    end else begin
      state       <= nxt_state;
      req_pc      <= nxt_req_pc;
      discard     <= nxt_discard;
      adef        <= nxt_adef;
      req_q       <= (nxt_state == PF_REQ);
      addr_q      <= nxt_req_pc;
      pf_if_valid <= (nxt_state == PF_HOLD);
      pf_if_bus   <= (nxt_state == PF_HOLD) ? {nxt_discard, nxt_adef, nxt_req_pc} : '0;
    end
  end

  assign inst_sram.req   = req_q;
  assign inst_sram.addr  = addr_q;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'b0000;
  assign inst_sram.wdata = 32'd0;

endmodule

// File: tb/tb_pre_if.sv
// tb/tb_pre_if.sv - directed and randomized checks of the pre-fetch stage against a fetch-stream model
module tb_pre_if;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_allowin;
  logic        pf_if_valid;
  logic [33:0] pf_if_bus;
  logic        br_taken;
  logic [31:0] br_target;
  logic [32:0] id_if_bus;
  logic        wb_ex;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] ertn_entry;

  int total = 0;
  int bad   = 0;

  pre_if_if sram ();

  assign id_if_bus = {br_taken, br_target};

  pre_if dut (
    .clk         (clk),
    .resetn      (resetn),
    .if_allowin  (if_allowin),
    .pf_if_valid (pf_if_valid),
    .pf_if_bus   (pf_if_bus),
    .id_if_bus   (id_if_bus),
    .wb_ex       (wb_ex),
    .ex_entry    (ex_entry),
    .ertn_flush  (ertn_flush),
    .ertn_entry  (ertn_entry),
    .inst_sram   (sram)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch-stream model state
  logic [31:0] exp_pc;
  int          pend_kind;
  bit          cur_red;
  int          ngood;
  bit          prev_wait;
  logic [31:0] prev_addr;
  bit          in_flight, deliver;
  int          kind;
  logic [31:0] tgt, r;
  int          sel;

  initial begin
    resetn = 1'b0; if_allowin = 1'b1; sram.addr_ok = 1'b1;
    br_taken = 1'b0; br_target = '0; wb_ex = 1'b0; ex_entry = '0;
    ertn_flush = 1'b0; ertn_entry = '0;
    tick; tick;
    chk("rst_req",   {63'd0, sram.req}, 64'd0);
    chk("rst_valid", {63'd0, pf_if_valid}, 64'd0);
    chk("rst_bus",   {30'd0, pf_if_bus}, 64'd0);
    chk("tie_size",  {62'd0, sram.size}, 64'd2);
    resetn = 1'b1;

    tick;
    chk("seq0_req",   {63'd0, sram.req}, 64'd1);
    chk("seq0_addr",  {32'd0, sram.addr}, 64'h1c000000);
    chk("seq0_valid", {63'd0, pf_if_valid}, 64'd0);
    tick;
    chk("seq0_hvalid", {63'd0, pf_if_valid}, 64'd1);
    chk("seq0_bus",    {30'd0, pf_if_bus}, {30'd0, 1'b0, 1'b0, 32'h1c000000});
    chk("seq0_hreq",   {63'd0, sram.req}, 64'd0);
    sram.addr_ok = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req",   {63'd0, sram.req}, 64'd1);
      chk("wait_addr",  {32'd0, sram.addr}, 64'h1c000004);
      chk("wait_valid", {63'd0, pf_if_valid}, 64'd0);
      if (i == 3) sram.addr_ok = 1'b1;
      tick;
    end
    chk("seq1_bus", {30'd0, pf_if_bus}, {30'd0, 1'b0, 1'b0, 32'h1c000004});
    tick;
    chk("seq2_addr", {32'd0, sram.addr}, 64'h1c000008);
    sram.addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1c000100;
    tick;
    br_taken = 1'b0; sram.addr_ok = 1'b1;
    chk("br_req_hold", {63'd0, sram.req}, 64'd1);
    chk("br_addr_hold", {32'd0, sram.addr}, 64'h1c000008);
    tick;
    chk("br_disc_bus", {30'd0, pf_if_bus}, {30'd0, 1'b1, 1'b0, 32'h1c000008});
    tick;
    chk("br_tgt_addr", {32'd0, sram.addr}, 64'h1c000100);

    sram.addr_ok = 1'b0; wb_ex = 1'b1; ex_entry = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200;
    tick;
    wb_ex = 1'b0; br_target = 32'h1c000300; sram.addr_ok = 1'b1;
    tick;
    br_taken = 1'b0;
    chk("ex_disc_bus", {30'd0, pf_if_bus}, {30'd0, 1'b1, 1'b0, 32'h1c000100});
    tick;
    chk("ex_tgt_addr", {32'd0, sram.addr}, 64'h1c008000);
    tick;
    chk("ex_bus", {30'd0, pf_if_bus}, {30'd0, 1'b0, 1'b0, 32'h1c008000});
    br_taken = 1'b1; br_target = 32'h1c000102;
    tick;
    br_taken = 1'b0;
    chk("adef_noreq", {63'd0, sram.req}, 64'd0);
    chk("adef_valid", {63'd0, pf_if_valid}, 64'd1);
    chk("adef_bus",   {30'd0, pf_if_bus}, {30'd0, 1'b0, 1'b1, 32'h1c000102});
    tick;
    repeat (2) begin
      chk("stall_valid", {63'd0, pf_if_valid}, 64'd0);
      chk("stall_req",   {63'd0, sram.req}, 64'd0);
      tick;
    end
    wb_ex = 1'b1; ex_entry = 32'h1c008000;
    tick;
    wb_ex = 1'b0;
    chk("stall_ex_req",  {63'd0, sram.req}, 64'd1);
    chk("stall_ex_addr", {32'd0, sram.addr}, 64'h1c008000);

    sram.addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_req",   {63'd0, sram.req}, 64'd0);
    chk("arst_valid", {63'd0, pf_if_valid}, 64'd0);
    tick; tick;
    sram.addr_ok = 1'b1; resetn = 1'b1;
    tick;
    chk("restart_req",  {63'd0, sram.req}, 64'd1);
    chk("restart_addr", {32'd0, sram.addr}, 64'h1c000000);

    // Randomized phase against the fetch-stream model
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    exp_pc = 32'h1c000000; pend_kind = 0; cur_red = 1'b0; ngood = 0; prev_wait = 1'b0; prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_wait) begin
        chk("rnd_req_held",  {63'd0, sram.req}, 64'd1);
        chk("rnd_addr_held", {32'd0, sram.addr}, {32'd0, prev_addr});
      end
      chk("rnd_one_phase", {63'd0, sram.req & pf_if_valid}, 64'd0);

      if_allowin   = ($urandom_range(0, 3) != 0);
      sram.addr_ok = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 15);
      r = $urandom(); br_target  = {r[31:2], 2'b00};
      r = $urandom(); ex_entry   = {r[31:2], 2'b00};
      r = $urandom(); ertn_entry = {r[31:2], 2'b00};
      br_taken   = (sel == 0) || (sel == 1) || (sel == 4);
      wb_ex      = (sel == 2) || (sel == 4);
      ertn_flush = (sel == 3);

      in_flight = sram.req || (pf_if_valid && !if_allowin);
      deliver   = pf_if_valid && if_allowin;
      if (deliver) begin
        chk("rnd_discard", {63'd0, pf_if_bus[33]}, {63'd0, cur_red});
        if (!cur_red) begin
          chk("rnd_pc",   {32'd0, pf_if_bus[31:0]}, {32'd0, exp_pc});
          chk("rnd_adef", {63'd0, pf_if_bus[32]}, 64'd0);
          exp_pc = exp_pc + 32'd4;
          ngood++;
        end
        cur_red = 1'b0;
        pend_kind = 0;
      end

      kind = wb_ex ? 1 : ertn_flush ? 2 : br_taken ? 3 : 0;
      tgt  = (kind == 1) ? ex_entry : (kind == 2) ? ertn_entry : br_target;
      if (kind != 0) begin
        if (in_flight) begin
          cur_red = 1'b1;
          if (!(kind == 3 && (pend_kind == 1 || pend_kind == 2))) begin
            exp_pc = tgt;
            pend_kind = kind;
          end
        end else begin
          exp_pc = tgt;
          pend_kind = 0;
        end
      end

      prev_wait = sram.req && !sram.addr_ok;
      prev_addr = sram.addr;
      tick;
    end
    br_taken = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
    chk("rnd_progress", {63'd0, (ngood > 100)}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
